// File: rtl/uart_tx_dec.sv
// Binary-to-decimal ASCII UART transmitter: latches a value, converts it with
// sequential double-dabble and sends its digits MSD first as 8N1 frames.
module uart_tx_dec #(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             txd,
  output logic             busy,
  output logic             done
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int CONV_W = $clog2(WIDTH + 1);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(WIDTH - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV      = 3'd1,
    LOAD      = 3'd2,
    START_BIT = 3'd3,
    DATA      = 3'd4,
    STOP_BIT  = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [WIDTH-1:0]    val_r;
  logic [BCD_W-1:0]    bcd_r;
  logic [CONV_W-1:0]   conv_cnt_r;
  logic [TICK_W-1:0]   tick_r;
  logic [2:0]          bit_idx_r;
  logic [DIG_W-1:0]    dig_idx_r;

  logic                accept_s;
  logic                tick_end_s;
  logic [BCD_W-1:0]    bcd_adj_s;
  logic [BCD_W-1:0]    bcd_next_s;
  logic [3:0]          digit_s;
  logic [7:0]          char_s;
  logic                txd_s;
  logic                busy_s;
  logic                done_s;

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = b[4*i +: 4];
    end
    return r;
  endfunction

  // Highest nonzero nibble; an all-zero register yields digit 0 so "0" is sent.
  function automatic logic [DIG_W-1:0] msd_index(input logic [BCD_W-1:0] b);
    logic [DIG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) idx = DIG_W'(i);
      else                     idx = idx;
    end
    return idx;
  endfunction

  // Request qualification, conversion step and current character.
  always_comb begin
    accept_s   = (state_r == IDLE) && start && !busy;
    tick_end_s = (tick_r == TICK_LAST);
    bcd_adj_s  = bcd_adjust(bcd_r);
    bcd_next_s = (bcd_adj_s << 1) | {{(BCD_W-1){1'b0}}, val_r[WIDTH-1]};
    digit_s    = bcd_r[4*int'(dig_idx_r) +: 4];
    char_s     = 8'h30 + {4'd0, digit_s};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next state and the values the output flops take on the coming edge.
  always_comb begin
    state_s = state_r;
    txd_s   = 1'b1;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = accept_s;
        done_s = busy;
        if (accept_s) state_s = CONV;
        else          state_s = IDLE;
      end
      CONV: begin
        if (conv_cnt_r == CONV_LAST) state_s = LOAD;
        else                         state_s = CONV;
      end
      LOAD: state_s = START_BIT;
      START_BIT: begin
        txd_s = 1'b0;
        if (tick_end_s) state_s = DATA;
        else            state_s = START_BIT;
      end
      DATA: begin
        txd_s = char_s[bit_idx_r];
        if (tick_end_s && (bit_idx_r == 3'd7)) state_s = STOP_BIT;
        else                                   state_s = DATA;
      end
      STOP_BIT: begin
        if (tick_end_s && (dig_idx_r != '0)) state_s = START_BIT;
        else if (tick_end_s)                 state_s = IDLE;
        else                                 state_s = STOP_BIT;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Outputs are flops one cycle behind the state, so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd  <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      txd  <= txd_s;
      busy <= busy_s;
      done <= done_s;
    end
  end

  // Conversion datapath, bit timing and digit sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_r      <= '0;
      bcd_r      <= '0;
      conv_cnt_r <= '0;
      tick_r     <= '0;
      bit_idx_r  <= 3'd0;
      dig_idx_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          tick_r    <= '0;
          bit_idx_r <= 3'd0;
          if (accept_s) begin
            val_r      <= value;
            bcd_r      <= '0;
            conv_cnt_r <= '0;
          end
        end
        CONV: begin
          bcd_r      <= bcd_next_s;
          val_r      <= val_r << 1;
          conv_cnt_r <= conv_cnt_r + CONV_W'(1);
        end
        LOAD: begin
          dig_idx_r <= msd_index(bcd_r);
          tick_r    <= '0;
          bit_idx_r <= 3'd0;
        end
        START_BIT: begin
          tick_r <= tick_end_s ? '0 : tick_r + TICK_W'(1);
        end
        DATA: begin
          tick_r <= tick_end_s ? '0 : tick_r + TICK_W'(1);
          if (tick_end_s) bit_idx_r <= bit_idx_r + 3'd1;
        end
        STOP_BIT: begin
          tick_r <= tick_end_s ? '0 : tick_r + TICK_W'(1);
          if (tick_end_s && (dig_idx_r != '0)) dig_idx_r <= dig_idx_r - DIG_W'(1);
        end
        default: begin
          tick_r    <= '0;
          bit_idx_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_dec.sv
// Directed bench for uart_tx_dec: decodes txd frames at mid-bit and checks
// latency, busy/done timing, request rejection and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_tx_dec;

  localparam int W     = 8;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  localparam int LAT   = W + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] value;
  logic       txd;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_dec #(.WIDTH(W), .DIGITS(3), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offsets o count negedges after acceptance edge N; start bit begins at o=LAT.
  task automatic send(input logic [7:0] v, input int k, input logic [23:0] chars,
                      input int inj_off, input bit hold, input string tag);
    int         done_cnt;
    int         last;
    int         rel;
    int         r;
    int         b;
    int         ncyc;
    logic [9:0] fr;
    logic [7:0] ch;
    done_cnt = 0;
    fr       = '0;
    last     = LAT + k * FRAME;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    for (int o = 0; o <= last + 2; o++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (o == 0) begin
        check_eq({tag, "_busy_rise"}, busy, 1);
        start = 1'b0;
        value = 8'hAA;
      end
      if (o == LAT - 1) check_eq({tag, "_pre_start_txd"}, txd, 1);
      if (o == LAT)     check_eq({tag, "_start_edge_txd"}, txd, 0);
      if (o >= LAT && o < last) begin
        rel = o - LAT;
        r   = rel % FRAME;
        if (r % CPB == CPB / 2) begin
          b     = r / CPB;
          fr[b] = txd;
          if (b == 9) begin
            ch = chars[8 * (2 - rel / FRAME) +: 8];
            check_eq({tag, "_frame"}, {22'd0, fr}, {22'd0, 1'b1, ch, 1'b0});
          end
        end
      end
      if (o == last - 1) begin
        check_eq({tag, "_busy_before_end"}, busy, 1);
        check_eq({tag, "_done_before_end"}, done, 0);
      end
      if (o == last) begin
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_done_end"}, done, 1);
      end
      if (o == last + 1) check_eq({tag, "_done_fall"}, done, 0);
      if (inj_off > 0 && o == inj_off) begin
        start = 1'b1;
        value = 8'd7;
      end
      if (inj_off > 0 && o == inj_off + 1) start = 1'b0;
      if (hold && o == last - 1) begin
        start = 1'b1;
        value = 8'd5;
      end
      if (hold && o == last + 1) begin
        check_eq({tag, "_restart_accept"}, busy, 1);
        start = 1'b0;
      end
    end
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    if (hold) begin
      // The restarted single-digit send must end LAT+FRAME edges after it was accepted.
      ncyc = 1;
      while (busy && ncyc < 1000) begin
        @(negedge clk);
        ncyc++;
      end
      check_eq({tag, "_restart_length"}, ncyc, LAT + FRAME);
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    value = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    send(8'd42,  2, {8'h34, 8'h32, 8'h00}, -1, 1'b0, "v42");
    send(8'd0,   1, {8'h30, 16'h0000},     -1, 1'b1, "v0");
    send(8'd255, 3, {8'h32, 8'h35, 8'h35}, -1, 1'b0, "v255");
    send(8'd100, 3, {8'h31, 8'h30, 8'h30}, -1, 1'b0, "v100");
    send(8'd42,  2, {8'h34, 8'h32, 8'h00}, LAT + FRAME + 30, 1'b0, "v42_inj");

    @(negedge clk);
    value = 8'd255;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    check_eq("mid_data_txd", txd, 0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_txd", txd, 1);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_txd", txd, 1);

    send(8'd9, 1, {8'h39, 16'h0000}, -1, 1'b0, "v9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
